fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 11 +
 rtl/fetch_timeout_ctr.sv | 21 ++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encoding and constants for the fetch stage.
package fetch_unit_pkg;
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: 16-bit saturating wait counter; o_expired flags that this enabled cycle reaches LIMIT.
module fetch_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    logic [15:0] r_count;
    logic [16:0] w_next;
    assign w_next    = {1'b0, r_count} + 17'd1;
    assign o_expired = w_next >= 17'(LIMIT);
    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_count <= '0;
        else if (i_en && !w_next[16])
            r_count <= w_next[15:0];
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and single-outstanding instruction fetch with misalignment and timeout trapping.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        retire,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_address,
    output logic        fetch_err,
    output logic [31:0] instret
);
    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_instr, w_instr_nxt;
    logic         r_instr_valid, w_instr_valid_nxt;
    logic         r_err, w_err_nxt;
    logic [31:0]  r_instret, w_instret_nxt;
    logic         w_clr, w_en, w_expired;

    fetch_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_en      (w_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= REQ;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_err         <= 1'b0;
            r_instret     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_err         <= w_err_nxt;
            r_instret     <= w_instret_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        w_err_nxt         = r_err;
        w_instret_nxt     = r_instret;
        w_clr             = 1'b0;
        w_en              = 1'b0;
        case (r_state)
            REQ: begin
                w_clr       = imem_req_ready;
                w_state_nxt = imem_req_ready ? WAIT : REQ;
            end
            WAIT: begin
                w_en = !imem_resp_valid;
                if (imem_resp_valid) begin
                    w_instr_nxt       = imem_resp_data;
                    w_instr_valid_nxt = 1'b1;
                    w_state_nxt       = HOLD;
                end else if (w_expired) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = HALT;
                end
            end
            HOLD: begin
                if (retire) begin
                    w_instret_nxt     = r_instret + 32'd1;
                    w_instr_valid_nxt = 1'b0;
                    // A misaligned target still retires the current instruction but never loads.
                    if (next_pc[1:0] == 2'b00) begin
                        w_pc_nxt    = next_pc;
                        w_state_nxt = REQ;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = HALT;
                    end
                end
            end
            default: w_instr_valid_nxt = 1'b0;
        endcase
    end

    assign imem_req_valid = (r_state == REQ) && !rst;
    assign imem_req_addr  = r_pc;
    assign pc_address     = r_pc;
    assign instr          = r_instr;
    assign instr_valid    = r_instr_valid;
    assign fetch_err      = r_err;
    assign instret        = r_instret;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, retire, stall, misalignment, timeout and reset abandonment.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] next_pc = '0;
    logic        retire = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_address;
    logic        fetch_err;
    logic [31:0] instret;
    int          total = 0;
    int          bad = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .next_pc         (next_pc),
        .retire          (retire),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .pc_address      (pc_address),
        .fetch_err       (fetch_err),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        tick();
        chk32("rst_pc", pc_address, 32'h0);
        chk32("rst_instr", instr, 32'h0000_0013);
        chk1("rst_ivalid", instr_valid, 1'b0);
        chk1("rst_reqv", imem_req_valid, 1'b0);
        chk1("rst_err", fetch_err, 1'b0);
        chk32("rst_instret", instret, 32'h0);
        rst = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk1("f1_reqv", imem_req_valid, 1'b1);
        chk32("f1_addr", imem_req_addr, 32'h0);
        tick();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h0050_0093;
        chk1("f1_wait_reqv", imem_req_valid, 1'b0);
        chk1("f1_wait_ivalid", instr_valid, 1'b0);
        tick();
        imem_resp_valid = 1'b0;
        chk1("f1_ivalid", instr_valid, 1'b1);
        chk32("f1_instr", instr, 32'h0050_0093);
        tick();
        chk1("f1_hold_ivalid", instr_valid, 1'b1);
        chk1("f1_hold_reqv", imem_req_valid, 1'b0);
        retire = 1'b1;
        next_pc = 32'h0000_0040;
        tick();
        retire = 1'b0;
        chk32("ret1_instret", instret, 32'h1);
        chk32("ret1_addr", imem_req_addr, 32'h40);
        chk1("ret1_ivalid", instr_valid, 1'b0);
        chk1("ret1_reqv", imem_req_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            retire = (i == 2);
            next_pc = 32'h0000_0080;
            tick();
            chk1("stall_reqv", imem_req_valid, 1'b1);
            chk32("stall_addr", imem_req_addr, 32'h40);
            chk1("stall_ivalid", instr_valid, 1'b0);
        end
        retire = 1'b0;
        chk32("stall_instret", instret, 32'h1);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk1("f2_wait_reqv", imem_req_valid, 1'b0);
        tick();
        tick();
        chk1("f2_wait_ivalid", instr_valid, 1'b0);
        chk1("f2_wait_err", fetch_err, 1'b0);
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h00a0_0113;
        tick();
        imem_resp_valid = 1'b0;
        chk1("f2_ivalid", instr_valid, 1'b1);
        chk32("f2_instr", instr, 32'h00a0_0113);
        retire = 1'b1;
        next_pc = 32'h0000_0042;
        tick();
        retire = 1'b0;
        chk1("mis_err", fetch_err, 1'b1);
        chk32("mis_pc", pc_address, 32'h40);
        chk32("mis_instret", instret, 32'h2);
        chk1("mis_ivalid", instr_valid, 1'b0);
        chk1("mis_reqv", imem_req_valid, 1'b0);
        imem_req_ready = 1'b1;
        tick();
        tick();
        chk1("halt_reqv", imem_req_valid, 1'b0);
        chk1("halt_err", fetch_err, 1'b1);
        rst = 1'b1;
        imem_req_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk32("rst2_pc", pc_address, 32'h0);
        chk1("rst2_err", fetch_err, 1'b0);
        chk32("rst2_instret", instret, 32'h0);
        chk1("rst2_reqv", imem_req_valid, 1'b1);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk1("to_err", fetch_err, i == 4);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h1234_5678;
        tick();
        imem_resp_valid = 1'b0;
        chk1("to_late_ivalid", instr_valid, 1'b0);
        chk1("to_halt_err", fetch_err, 1'b1);
        chk1("to_halt_reqv", imem_req_valid, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hdead_beef;
        tick();
        imem_resp_valid = 1'b0;
        chk1("stale_ivalid", instr_valid, 1'b0);
        chk32("stale_instr", instr, 32'h0000_0013);
        chk1("stale_reqv", imem_req_valid, 1'b1);
        chk32("stale_addr", imem_req_addr, 32'h0);
        chk1("stale_err", fetch_err, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
